// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch (F) and memory (M) stages.
// M has priority; a starvation counter forces an F grant after STARVE_MAX back-to-back M wins.
module mem_port_arbiter #(
  parameter int AW         = 64,
  parameter int DW         = 64,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic [DW-1:0] f_rdata,
  output logic          f_ack,
  input  logic          m_req,
  input  logic          m_we,
  input  logic [AW-1:0] m_addr,
  input  logic [DW-1:0] m_wdata,
  output logic [DW-1:0] m_rdata,
  output logic          m_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_F,
  output logic          stall_M
);

  // state  | meaning
  // IDLE   | sample requests, grant one and latch its access
  // ACCESS | mem_en strobe cycle, load the latency counter
  // WAIT   | count down the memory latency, capture read data at zero
  // DONE   | owner's ack pulse, back to IDLE
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT - 1);

  state_t     state;
  logic       owner_f;
  logic [3:0] wait_cnt;
  logic [3:0] starve_cnt;
  logic       grant_m;

  // F is forced only when both are requesting and F has waited long enough
  assign grant_m = m_req && !(f_req && (starve_cnt == STARVE_LIM));

  assign stall_F = f_req & ~f_ack;
  assign stall_M = m_req & ~m_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner_f    <= 1'b0;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      f_ack      <= 1'b0;
      m_ack      <= 1'b0;
      f_rdata    <= '0;
      m_rdata    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          f_ack <= 1'b0;
          m_ack <= 1'b0;
          if (grant_m) begin
            owner_f   <= 1'b0;
            mem_en    <= 1'b1;
            mem_we    <= m_we;
            mem_addr  <= m_addr;
            mem_wdata <= m_wdata;
            if (!f_req)
              starve_cnt <= '0;
            else if (starve_cnt != STARVE_LIM)
              starve_cnt <= starve_cnt + 4'd1;
            state <= ACCESS;
          end else if (f_req) begin
            owner_f    <= 1'b1;
            mem_en     <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= f_addr;
            mem_wdata  <= '0;
            starve_cnt <= '0;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          mem_en   <= 1'b0;
          wait_cnt <= LAT_LOAD;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            if (owner_f) begin
              f_rdata <= mem_rdata;
              f_ack   <= 1'b1;
            end else begin
              m_rdata <= mem_we ? '0 : mem_rdata;
              m_ack   <= 1'b1;
            end
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        DONE: begin
          f_ack <= 1'b0;
          m_ack <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
